// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit (Booth multiplier and non-restoring divider).
//   WIDTH : operand/result width
//   CNT_W : iteration counter width
//   div_state_e : divider sequencing states
package multdiv_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage : multdiv_pkg

// File: rtl/div_step.sv
// One radix-2 non-restoring division iteration (purely combinational).
//   rem        : current partial remainder, signed, WIDTH+1 bits
//   quo        : current quotient/dividend shift register
//   dvs        : divisor magnitude, WIDTH+1 bits (MSB is always 0)
//   rem_next_c : partial remainder after shift and add/subtract
//   quo_next_c : quotient register after shift, new bit in bit 0
module div_step
  import multdiv_pkg::*;
(
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   dvs,
  output logic [WIDTH:0]   rem_next_c,
  output logic [WIDTH-1:0] quo_next_c
);

  logic [WIDTH:0] rem_sh;

  // Shift {R,Q} left; the partial remainder stays within [-D, D), so the
  // sign of R before the shift is the sign used to pick add or subtract.
  assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};

  assign rem_next_c = rem[WIDTH] ? (rem_sh + dvs) : (rem_sh - dvs);
  assign quo_next_c = {quo[WIDTH-2:0], ~rem_next_c[WIDTH]};

endmodule : div_step

// File: rtl/div_nonrestoring.sv
// Sequential signed divider, radix-2 non-restoring, one quotient bit per cycle.
// Quotient truncates toward zero; divide by zero returns 0 with data_exception set.
// Optional feature macro: DIV_REMAINDER_EN adds data_remainder (sign follows dividend).
//   clock, reset_n  : clock and asynchronous active-low reset
//   ctrl_DIV        : start pulse, operands sampled on the same edge
//   ctrl_MULT       : multiply start on the shared unit, aborts any division
//   dividend        : signed operand A
//   divisor         : signed operand B
//   data_result     : signed quotient, held until the next start
//   data_resultRDY  : one-cycle done pulse, 33 cycles after the start edge
//   data_exception  : divide-by-zero flag, held with the result
//   data_remainder  : signed remainder (DIV_REMAINDER_EN only)
module div_nonrestoring
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_exception
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             neg_quo_q, neg_quo_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] result_d;
  logic             rdy_d;
  logic             exc_d;
  logic [WIDTH:0]   rem_step_c;
  logic [WIDTH-1:0] quo_step_c;
`ifdef DIV_REMAINDER_EN
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] remainder_d;
  logic [WIDTH-1:0] rem_fix_c;

  // Restore a negative final remainder by adding the divisor back once.
  assign rem_fix_c = rem_q[WIDTH] ? WIDTH'(rem_q + dvs_q) : rem_q[WIDTH-1:0];
`endif

  div_step u_step (
    .rem        (rem_q),
    .quo        (quo_q),
    .dvs        (dvs_q),
    .rem_next_c (rem_step_c),
    .quo_next_c (quo_step_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    neg_quo_d = neg_quo_q;
    dz_d      = dz_q;
    result_d  = data_result;
    exc_d     = data_exception;
    rdy_d     = 1'b0;
`ifdef DIV_REMAINDER_EN
    neg_rem_d   = neg_rem_q;
    remainder_d = data_remainder;
`endif

    if (ctrl_MULT) begin
      // Shared unit taken by the multiplier: drop the division silently.
      state_d = IDLE;
    end else if (ctrl_DIV) begin
      // Start (or restart) from any state with the magnitudes of the operands.
      state_d   = RUN;
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
      dvs_d     = {1'b0, (divisor[WIDTH-1] ? WIDTH'(-divisor) : divisor)};
      neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      dz_d      = (divisor == '0);
`ifdef DIV_REMAINDER_EN
      neg_rem_d = dividend[WIDTH-1];
`endif
    end else begin
      case (state_q)
        RUN: begin
          rem_d = rem_step_c;
          quo_d = quo_step_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
        FIX: begin
          if (dz_q) begin
            result_d = '0;
          end else begin
            result_d = neg_quo_q ? WIDTH'(-quo_q) : quo_q;
          end
          exc_d   = dz_q;
          rdy_d   = 1'b1;
          state_d = DONE;
`ifdef DIV_REMAINDER_EN
          if (dz_q) begin
            remainder_d = '0;
          end else begin
            remainder_d = neg_rem_q ? WIDTH'(-rem_fix_c) : rem_fix_c;
          end
`endif
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rem_q          <= '0;
      dvs_q          <= '0;
      quo_q          <= '0;
      neg_quo_q      <= 1'b0;
      dz_q           <= 1'b0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
      neg_rem_q      <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rem_q          <= rem_d;
      dvs_q          <= dvs_d;
      quo_q          <= quo_d;
      neg_quo_q      <= neg_quo_d;
      dz_q           <= dz_d;
      data_result    <= result_d;
      data_resultRDY <= rdy_d;
      data_exception <= exc_d;
`ifdef DIV_REMAINDER_EN
      neg_rem_q      <= neg_rem_d;
      data_remainder <= remainder_d;
`endif
    end
  end

endmodule : div_nonrestoring

// File: tb/tb_div_nonrestoring.sv
// Scoreboard bench for div_nonrestoring: stimulus pushes expected results
// computed with plain signed arithmetic; a monitor pops on every done pulse.
module tb_div_nonrestoring;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rem;
    int          due;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        ctrl_DIV;
  logic        ctrl_MULT;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_exception;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  div_nonrestoring dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .ctrl_MULT      (ctrl_MULT),
    .dividend       (dividend),
    .divisor        (divisor),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: signed division truncating toward zero, remainder follows dividend.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.due = 0;
    if (b == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
      e.rem = 32'd0;
    end else begin
      e.res = 32'(sa / sb);
      e.exc = 1'b0;
      e.rem = 32'(sa % sb);
    end
    return e;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Issue a start; any pending result is cancelled by the restart.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clock);
    exp_q.delete();
    e        = model(a, b);
    e.due    = cyc + 34;
    exp_q.push_back(e);
    ctrl_DIV = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic abort_mult();
    @(negedge clock);
    exp_q.delete();
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (exp_q.size() == 0) done = 1'b1;
      else @(negedge clock);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_done: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  initial begin
    exp_t e;
    logic prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) begin
        check1("rdy_width_prev", prev_rdy, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rdy: got result 0x%08h required no pulse", data_result);
        end else begin
          e = exp_q.pop_front();
          check32("latency_cycle", 32'(cyc), 32'(e.due));
          check32("result", data_result, e.res);
          check1("exception", data_exception, e.exc);
`ifdef DIV_REMAINDER_EN
          check32("remainder", data_remainder, e.rem);
`endif
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        checks++;
        failures++;
        $display("FAIL missing_rdy: got no pulse by cycle %0d required at %0d", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      prev_rdy = data_resultRDY;
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    reset_n   = 1'b0;
    ctrl_DIV  = 1'b0;
    ctrl_MULT = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    #3;
    check32("reset_result", data_result, 32'd0);
    check1("reset_rdy", data_resultRDY, 1'b0);
    check1("reset_exc", data_exception, 1'b0);
`ifdef DIV_REMAINDER_EN
    check32("reset_rem", data_remainder, 32'd0);
`endif
    idle_cycles(2);
    reset_n = 1'b1;
    idle_cycles(2);

    // Basic signs, divide by zero and the overflow corner.
    start_div(32'd100, 32'd7);                 wait_done();
    start_div(32'hFFFF_FF9C, 32'd7);           wait_done();
    start_div(32'd5, 32'd0);                   wait_done();
    idle_cycles(5);
    check32("dz_hold_result", data_result, 32'd0);
    check1("dz_hold_exc", data_exception, 1'b1);
    start_div(32'h8000_0000, 32'hFFFF_FFFF);   wait_done();
    start_div(32'h8000_0000, 32'd2);           wait_done();

    // Restart mid-operation: only the second op reports.
    start_div(32'd1000, 32'd3);
    idle_cycles(8);
    start_div(32'd9, 32'd3);                   wait_done();
    idle_cycles(3);

    // Multiply start aborts a division: no pulse, outputs hold.
    start_div(32'd77, 32'd5);
    idle_cycles(3);
    abort_mult();
    idle_cycles(40);
    check32("abort_hold_result", data_result, 32'd3);
    check1("abort_hold_exc", data_exception, 1'b0);

    // Simultaneous ctrl_MULT and ctrl_DIV: the abort wins, no start.
    @(negedge clock);
    ctrl_DIV  = 1'b1;
    ctrl_MULT = 1'b1;
    dividend  = 32'd50;
    divisor   = 32'd5;
    @(negedge clock);
    ctrl_DIV  = 1'b0;
    ctrl_MULT = 1'b0;
    idle_cycles(40);
    check32("both_hold_result", data_result, 32'd3);

    // Asynchronous reset mid-cycle during an operation.
    start_div(32'd12345, 32'd67);
    idle_cycles(11);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check32("async_rst_result", data_result, 32'd0);
    check1("async_rst_rdy", data_resultRDY, 1'b0);
    check1("async_rst_exc", data_exception, 1'b0);
    idle_cycles(2);
    reset_n = 1'b1;
    idle_cycles(40);
    start_div(32'd8, 32'd2);                   wait_done();

    // Randomized operands, sometimes back-to-back on the done cycle.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 7))
        0:       begin a = $urandom;      b = 32'd0;        end
        1:       begin a = 32'h8000_0000; b = $urandom;     end
        2:       begin a = $urandom;      b = 32'hFFFF_FFFF; end
        3:       begin a = $urandom;      b = 32'($urandom_range(1, 1000)); b = ($urandom_range(0, 1) == 1) ? -b : b; end
        default: begin a = $urandom;      b = $urandom;     end
      endcase
      start_div(a, b);
      wait_done();
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(0, 4));
    end

    idle_cycles(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_div_nonrestoring
